// File: rtl/id_stage.sv
// Purpose: MIPS-32 instruction decode stage: control decode, 32x32 register file with WB bypass, sign extension, load-use detection, ID/EX latch.
// Latency: one cycle from instr_in/npc_in to the ID/EX outputs; WB write to read is zero cycles through the bypass.
// Backpressure: stall is combinational; it holds PC and IF/ID upstream while this stage inserts a bubble into ID/EX.
//
// Ports:
//   clk, rst_n                          pipeline clock, asynchronous active-low reset
//   npc_in, instr_in                    PC+4 and instruction from the IF/ID latch
//   flush                               branch-taken squash, turns the next ID/EX capture into a bubble
//   wb_regwrite, wb_write_reg,
//   wb_write_data                       register-file write port driven by WB
//   stall                               load-use hazard indication to IF
//   wb_ctl_out {RegWrite, MemtoReg}, m_ctl_out {Branch, MemRead, MemWrite},
//   ex_ctl_out {RegDst, ALUOp[1:0], ALUSrc}, npc_out, rd1_out, rd2_out,
//   imm_out, rt_out, rd_out, rs_out     ID/EX latch contents

module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc_in,
    input  logic [31:0] instr_in,
    input  logic        flush,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    output logic        stall,
    output logic [1:0]  wb_ctl_out,
    output logic [2:0]  m_ctl_out,
    output logic [3:0]  ex_ctl_out,
    output logic [31:0] npc_out,
    output logic [31:0] rd1_out,
    output logic [31:0] rd2_out,
    output logic [31:0] imm_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [4:0]  rs_out
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // Instruction fields
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;

    assign w_opcode = instr_in[31:26];
    assign w_rs     = instr_in[25:21];
    assign w_rt     = instr_in[20:16];
    assign w_rd     = instr_in[15:11];
    assign w_imm    = instr_in[15:0];

    // Decoded control
    logic [1:0] w_wb_ctl;
    logic [2:0] w_m_ctl;
    logic [3:0] w_ex_ctl;

    always_comb begin
        w_wb_ctl = 2'b00;
        w_m_ctl  = 3'b000;
        w_ex_ctl = 4'b0000;
        case (w_opcode)
            OP_RTYPE: begin
                w_wb_ctl = 2'b10;     // RegWrite
                w_ex_ctl = 4'b1100;   // RegDst, ALUOp=10
            end
            OP_LW: begin
                w_wb_ctl = 2'b11;     // RegWrite, MemtoReg
                w_m_ctl  = 3'b010;    // MemRead
                w_ex_ctl = 4'b0001;   // ALUSrc
            end
            OP_SW: begin
                w_m_ctl  = 3'b001;    // MemWrite
                w_ex_ctl = 4'b0001;   // ALUSrc
            end
            OP_BEQ: begin
                w_m_ctl  = 3'b100;    // Branch
                w_ex_ctl = 4'b0010;   // ALUOp=01
            end
            default: ;                // unknown opcode decodes as a NOP
        endcase
    end

    // Register file; $0 is never written and always reads as zero
    logic [31:0] r_regs [32];
    logic        w_wb_we;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    assign w_wb_we = wb_regwrite && (wb_write_reg != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_wb_we) begin
            r_regs[wb_write_reg] <= wb_write_data;
        end
    end

    // Write-first bypass: a same-cycle WB write to the register being read wins
    always_comb begin
        if (w_rs == 5'd0)
            w_rd1 = 32'd0;
        else if (w_wb_we && (wb_write_reg == w_rs))
            w_rd1 = wb_write_data;
        else
            w_rd1 = r_regs[w_rs];

        if (w_rt == 5'd0)
            w_rd2 = 32'd0;
        else if (w_wb_we && (wb_write_reg == w_rt))
            w_rd2 = wb_write_data;
        else
            w_rd2 = r_regs[w_rt];
    end

    // ID/EX latch
    logic [1:0]  r_wb_ctl;
    logic [2:0]  r_m_ctl;
    logic [3:0]  r_ex_ctl;
    logic [31:0] r_npc;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic [31:0] r_imm;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs;
    logic        w_stall;
    logic        w_bubble;

    // A load now in ID/EX whose destination is a source of the instruction in ID
    assign w_stall  = r_m_ctl[1] && (r_rt != 5'd0) && ((r_rt == w_rs) || (r_rt == w_rt));
    assign w_bubble = flush || w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_ctl <= 2'b00;
            r_m_ctl  <= 3'b000;
            r_ex_ctl <= 4'b0000;
            r_npc    <= 32'd0;
            r_rd1    <= 32'd0;
            r_rd2    <= 32'd0;
            r_imm    <= 32'd0;
            r_rt     <= 5'd0;
            r_rd     <= 5'd0;
            r_rs     <= 5'd0;
        end else begin
            // Only the controls are squashed; data fields load regardless
            r_wb_ctl <= w_bubble ? 2'b00   : w_wb_ctl;
            r_m_ctl  <= w_bubble ? 3'b000  : w_m_ctl;
            r_ex_ctl <= w_bubble ? 4'b0000 : w_ex_ctl;
            r_npc    <= npc_in;
            r_rd1    <= w_rd1;
            r_rd2    <= w_rd2;
            r_imm    <= {{16{w_imm[15]}}, w_imm};
            r_rt     <= w_rt;
            r_rd     <= w_rd;
            r_rs     <= w_rs;
        end
    end

    assign stall      = w_stall;
    assign wb_ctl_out = r_wb_ctl;
    assign m_ctl_out  = r_m_ctl;
    assign ex_ctl_out = r_ex_ctl;
    assign npc_out    = r_npc;
    assign rd1_out    = r_rd1;
    assign rd2_out    = r_rd2;
    assign imm_out    = r_imm;
    assign rt_out     = r_rt;
    assign rd_out     = r_rd;
    assign rs_out     = r_rs;

endmodule

// File: tb/tb_id_stage.sv
// Purpose: directed self-checking bench for id_stage.
// Latency: inputs driven 1ns after a rising edge; registered outputs sampled 1ns after the next edge.
// Backpressure: stall is sampled combinationally before the capturing edge.

module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] npc_in;
    logic [31:0] instr_in;
    logic        flush;
    logic        wb_regwrite;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        stall;
    logic [1:0]  wb_ctl_out;
    logic [2:0]  m_ctl_out;
    logic [3:0]  ex_ctl_out;
    logic [31:0] npc_out;
    logic [31:0] rd1_out;
    logic [31:0] rd2_out;
    logic [31:0] imm_out;
    logic [4:0]  rt_out;
    logic [4:0]  rd_out;
    logic [4:0]  rs_out;

    int n_checks = 0;
    int n_fail   = 0;

    id_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .npc_in        (npc_in),
        .instr_in      (instr_in),
        .flush         (flush),
        .wb_regwrite   (wb_regwrite),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .stall         (stall),
        .wb_ctl_out    (wb_ctl_out),
        .m_ctl_out     (m_ctl_out),
        .ex_ctl_out    (ex_ctl_out),
        .npc_out       (npc_out),
        .rd1_out       (rd1_out),
        .rd2_out       (rd2_out),
        .imm_out       (imm_out),
        .rt_out        (rt_out),
        .rd_out        (rd_out),
        .rs_out        (rs_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        wb_regwrite   = 1'b1;
        wb_write_reg  = r;
        wb_write_data = d;
        tick();
        wb_regwrite   = 1'b0;
    endtask

    task automatic check_ctl(input string tag, input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex);
        check({tag, ".wb"}, {30'd0, wb_ctl_out}, {30'd0, wb});
        check({tag, ".m"},  {29'd0, m_ctl_out},  {29'd0, m});
        check({tag, ".ex"}, {28'd0, ex_ctl_out}, {28'd0, ex});
    endtask

    task automatic check_all_zero(input string tag);
        check_ctl(tag, 2'b00, 3'b000, 4'b0000);
        check({tag, ".npc"},   npc_out, 32'd0);
        check({tag, ".rd1"},   rd1_out, 32'd0);
        check({tag, ".rd2"},   rd2_out, 32'd0);
        check({tag, ".imm"},   imm_out, 32'd0);
        check({tag, ".rt"},    {27'd0, rt_out}, 32'd0);
        check({tag, ".rd"},    {27'd0, rd_out}, 32'd0);
        check({tag, ".rs"},    {27'd0, rs_out}, 32'd0);
        check({tag, ".stall"}, {31'd0, stall},  32'd0);
    endtask

    initial begin
        logic [31:0] instr_v;

        // Reset with arbitrary, active-looking inputs
        rst_n         = 1'b0;
        npc_in        = 32'h0000_1234;
        instr_in      = 32'h8C22_0004;
        flush         = 1'b0;
        wb_regwrite   = 1'b1;
        wb_write_reg  = 5'd1;
        wb_write_data = 32'hFFFF_FFFF;
        repeat (3) tick();
        check_all_zero("reset");

        wb_regwrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Every register reads zero after reset (checked through the latch)
        for (int i = 1; i < 32; i++) begin
            instr_v  = {6'h00, i[4:0], i[4:0], 5'd0, 11'd0};
            instr_in = instr_v;
            tick();
            check($sformatf("rf_zero.rd1[%0d]", i), rd1_out, 32'd0);
            check($sformatf("rf_zero.rd2[%0d]", i), rd2_out, 32'd0);
        end

        // R-type decode: add $3,$1,$2
        instr_in = 32'h0000_0000;
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd7);
        npc_in   = 32'h0000_0104;
        instr_in = 32'h0022_1820;
        tick();
        check_ctl("rtype", 2'b10, 3'b000, 4'b1100);
        check("rtype.rd1", rd1_out, 32'd5);
        check("rtype.rd2", rd2_out, 32'd7);
        check("rtype.rd",  {27'd0, rd_out}, 32'd3);
        check("rtype.rs",  {27'd0, rs_out}, 32'd1);
        check("rtype.rt",  {27'd0, rt_out}, 32'd2);
        check("rtype.npc", npc_out, 32'h0000_0104);

        // Load-use: lw $2,4($1) then add $4,$2,$5
        npc_in   = 32'h0000_0200;
        instr_in = 32'h8C22_0004;
        #1;
        check("lw.stall_pre", {31'd0, stall}, 32'd0);
        tick();
        check_ctl("lw", 2'b11, 3'b010, 4'b0001);
        check("lw.imm", imm_out, 32'd4);
        check("lw.rt",  {27'd0, rt_out}, 32'd2);
        npc_in   = 32'h0000_0204;
        instr_in = 32'h0045_2020;
        #1;
        check("lu.stall", {31'd0, stall}, 32'd1);
        tick();
        check_ctl("lu.bubble", 2'b00, 3'b000, 4'b0000);
        check("lu.stall_drop", {31'd0, stall}, 32'd0);
        tick();
        check_ctl("lu.add", 2'b10, 3'b000, 4'b1100);
        check("lu.add.rd", {27'd0, rd_out}, 32'd4);
        check("lu.add.rd1", rd1_out, 32'd7);
        check("lu.add.stall", {31'd0, stall}, 32'd0);

        // Bypass: WB writes $6 in the same cycle as add $7,$6,$0 reads it
        instr_in      = 32'h00C0_3820;
        wb_regwrite   = 1'b1;
        wb_write_reg  = 5'd6;
        wb_write_data = 32'hDEAD_BEEF;
        tick();
        wb_regwrite   = 1'b0;
        check("byp.rd1", rd1_out, 32'hDEAD_BEEF);
        check("byp.rd2", rd2_out, 32'd0);
        tick();
        check("byp.held", rd1_out, 32'hDEAD_BEEF);

        // $0 write ignored, both in the same cycle and afterwards
        instr_in      = 32'h0000_3820;
        wb_regwrite   = 1'b1;
        wb_write_reg  = 5'd0;
        wb_write_data = 32'h0000_1234;
        tick();
        wb_regwrite   = 1'b0;
        check("r0.same.rd1", rd1_out, 32'd0);
        tick();
        check("r0.later.rd1", rd1_out, 32'd0);
        check("r0.later.rd2", rd2_out, 32'd0);

        // beq $1,$2,-1
        instr_in = 32'h1022_FFFF;
        tick();
        check_ctl("beq", 2'b00, 3'b100, 4'b0010);
        check("beq.imm", imm_out, 32'hFFFF_FFFF);
        check("beq.rd1", rd1_out, 32'd5);
        check("beq.rd2", rd2_out, 32'd7);

        // sw $2,-8($1) and an unsupported opcode (j)
        instr_in = 32'hAC22_FFF8;
        tick();
        check_ctl("sw", 2'b00, 3'b001, 4'b0001);
        check("sw.imm", imm_out, 32'hFFFF_FFF8);
        instr_in = 32'h0800_0010;
        tick();
        check_ctl("nop", 2'b00, 3'b000, 4'b0000);
        check("nop.imm", imm_out, 32'h0000_0010);

        // Flush on an R-type
        npc_in   = 32'hABCD_0000;
        instr_in = 32'h0022_1820;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        check_ctl("flush", 2'b00, 3'b000, 4'b0000);
        check("flush.npc", npc_out, 32'hABCD_0000);
        check("flush.rd",  {27'd0, rd_out}, 32'd3);

        // Stall and flush together: bubble, stall still visible
        instr_in = 32'h8C22_0004;
        tick();
        instr_in = 32'h0041_2020;       // add $4,$2,$1 uses $2 as rs
        flush    = 1'b1;
        #1;
        check("sf.stall", {31'd0, stall}, 32'd1);
        tick();
        flush    = 1'b0;
        check_ctl("sf.bubble", 2'b00, 3'b000, 4'b0000);

        // Reset mid-stall clears stall combinationally
        instr_in = 32'h8C22_0004;
        tick();
        instr_in = 32'h0045_2020;
        #1;
        check("rs.stall_pre", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rs.stall", {31'd0, stall}, 32'd0);
        check_ctl("rs.ctl", 2'b00, 3'b000, 4'b0000);
        check("rs.npc", npc_out, 32'd0);
        tick();
        check("rs.rd2", rd2_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rs.regs_cleared", rd1_out, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of the IF stage and its IF/ID latch. It consumes the latched next-PC and instruction, decodes the main control signals, and reads the 32x32 register file, which it owns and which the WB stage writes through this block. It sign-extends the immediate, detects load-use hazards to stall IF, and registers everything into the ID/EX latch consumed by EX.

## Interface
Parameters:
- none; widths are fixed to MIPS-32.

Ports:
- clk  in  1  single pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- npc_in  in  32  PC+4 from IF/ID latch.
- instr_in  in  32  instruction from IF/ID latch.
- flush  in  1  branch-taken squash from MEM; inserts a bubble into ID/EX.
- wb_regwrite  in  1  WB register-write enable.
- wb_write_reg  in  5  WB destination register.
- wb_write_data  in  32  WB write data.
- stall  out  1  combinational; holds PC and IF/ID when high.
- wb_ctl_out  out  2  {RegWrite, MemtoReg}.
- m_ctl_out  out  3  {Branch, MemRead, MemWrite}.
- ex_ctl_out  out  4  {RegDst, ALUOp[1:0], ALUSrc}.
- npc_out  out  32  registered npc_in.
- rd1_out  out  32  register file value of rs.
- rd2_out  out  32  register file value of rt.
- imm_out  out  32  sign-extended instr[15:0].
- rt_out  out  5  instr[20:16].
- rd_out  out  5  instr[15:11].
- rs_out  out  5  instr[25:21].

## Operation
- Field split: opcode=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- Decode, given as RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp:
  - opcode 0x00 (R-type): 1,0,0,1,0,0,0,10.
  - 0x23 (lw): 0,1,1,1,1,0,0,00.
  - 0x2B (sw): 0,1,0,0,0,1,0,00.
  - 0x04 (beq): 0,0,0,0,0,0,1,01.
  - any other opcode: all zero, treated as a NOP.
- Register file: 32 x 32-bit. Written on the rising edge when wb_regwrite=1 and wb_write_reg!=0. Writes to $0 are ignored, and $0 always reads 0.
- Read bypass: if wb_regwrite=1, wb_write_reg!=0, and wb_write_reg equals rs (or rt), the read returns wb_write_data in the same cycle. This is the write-first-half/read-second-half rule.
- Sign extension: imm_out = {{16{imm[15]}}, imm}.
- Load-use hazard: stall = m_ctl_out.MemRead & (rt_out!=0) & (rt_out==rs | rt_out==rt). rs and rt here are taken from the current instr_in.
- ID/EX latch update on each rising edge:
  - if flush=1 or stall=1, wb/m/ex control fields load 0 (bubble); data fields still load normally.
  - otherwise all fields load the decoded and read values.
- flush has priority over stall; a flushed cycle is simply a bubble.
- The upstream IF/ID latch and PC are held by stall; this block does not gate them itself.

## Timing
- Reset (rst_n=0, asynchronous): all ID/EX outputs become 0 immediately, all 32 registers become 0, and stall=0.
- Reset release: the first capture happens on the first rising edge with rst_n=1.
- Latency: instr_in/npc_in to ID/EX outputs takes one cycle. WB write to a subsequent read takes zero cycles because of the bypass.
- Stall duration: exactly one cycle per load-use pair. The next cycle, m_ctl_out.MemRead=0 (bubble), so stall drops. The held instruction then re-decodes and proceeds.
- Simultaneous stall and flush: a bubble is inserted. stall is still asserted, but IF flushes regardless.
- Simultaneous WB write and a read of the same register: the new data is read.
- Reset asserted mid-stall: stall drops combinationally with the cleared latch.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs -> every output is 0 and stall=0. Then read $1..$31 via instr_in -> all zero.
- R-type decode: preload $1=5 and $2=7 through WB, then instr_in=0x00221820 (add $3,$1,$2) -> next edge shows wb_ctl=10, m_ctl=000, ex_ctl=1100, rd1=5, rd2=7, rd_out=3.
- Load-use: lw $2,4($1) (0x8C220004) followed by add $4,$2,$5 (0x00452020) -> stall=1 for exactly one cycle and a bubble (all controls 0) in ID/EX. The add is captured on the following edge.
- Bypass and $0: in the same cycle, WB writes $6=0xDEADBEEF while instr_in reads rs=6 -> rd1_out=0xDEADBEEF. A WB write of $0=0x1234 -> a later read of $0 returns 0.
- Branch and sign extension: instr_in=0x1022FFFF (beq $1,$2,-1) -> m_ctl=100, ALUOp=01, imm_out=0xFFFFFFFF.
- Flush: assert flush while instr_in is an R-type -> all controls are 0 on the next edge, and npc_out still updates.
